// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and mode constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder, the arithmetic core of serial_addsub.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial add/subtract with start/busy/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to enable the signed-overflow output; otherwise ovf is tied low.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             eq,
  output logic             ovf
);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, acc_q, acc_d, mode_q, mode_d;
  logic             cout_q, cout_d, eq_q, eq_d;
  logic             fa_s, fa_co, take, last;

  assign take = start && state_q != RUN;
  assign last = cnt_q == LAST;

  full_adder_cell u_fa (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(fa_s), .co(fa_co));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb
    state_d = take ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;

  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end

  // b is stored pre-inverted in subtract mode; mode_q recovers the raw bit for the eq chain
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    eq_d    = eq_q;
    if (take) begin
      a_d     = a;
      b_d     = mode == MODE_SUB ? ~b : b;
      mode_d  = mode;
      carry_d = mode == MODE_SUB ? 1'b1 : cin;
      acc_d   = 1'b1;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_co;
      acc_d   = acc_q & ~(a_q[0] ^ b_q[0] ^ mode_q);
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d  = res_d;
        cout_d = fa_co;
        eq_d   = acc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= 1'b0;
      mode_q  <= MODE_ADD;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      eq_q    <= eq_d;
    end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign eq   = eq_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  // carry_q during the last RUN cycle is the carry into the MSB cell
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last && !take) ovf_q <= carry_q ^ fa_co;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vector table plus handshake, reset and width-sweep sequences for serial_addsub.
module tb_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, mode = 0, cin = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic busy, done, cout, eq, ovf;
  logic start2 = 0, mode2 = 0, cin2 = 0, busy2, done2, cout2, eq2, ovf2;
  logic [1:0] a2 = 0, b2 = 0, sum2;
  logic start32 = 0, mode32 = 0, cin32 = 0, busy32, done32, cout32, eq32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, sum32;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .eq(eq), .ovf(ovf));
  serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .eq(eq2), .ovf(ovf2));
  serial_addsub #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .cin(cin32), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .eq(eq32), .ovf(ovf32));

  typedef struct {
    logic m; logic [7:0] a, b; logic ci;
    logic [7:0] s; logic co, e, o;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] model(input int w, input logic m, input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    return m ? ({32'b0, x} + ({32'b0, ~y} & mask) + 64'd1) : ({32'b0, x} + {32'b0, y} + {63'b0, c});
  endfunction

  task automatic op8(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                     output int lat, output logic bok);
    @(negedge clk);
    mode = m; a = av; b = bv; cin = ci; start = 1;
    @(posedge clk); #1;
    start = 0; a = 8'($urandom); b = 8'($urandom); mode = ~m; cin = ~ci;
    lat = 0; bok = 1;
    do begin
      if (!busy) bok = 0;
      @(posedge clk); #1; lat++;
    end while (!done && lat < 40);
  endtask

  task automatic op2(input logic m, input logic [1:0] av, input logic [1:0] bv, input logic ci);
    int lat = 0;
    logic [63:0] r = model(2, m, {30'b0, av}, {30'b0, bv}, ci);
    @(negedge clk);
    mode2 = m; a2 = av; b2 = bv; cin2 = ci; start2 = 1;
    @(posedge clk); #1;
    start2 = 0; a2 = ~av;
    do begin @(posedge clk); #1; lat++; end while (!done2 && lat < 40);
    chk("w2_latency", 64'(lat), 64'd2);
    chk("w2_sum", {62'b0, sum2}, r & 64'h3);
    chk("w2_cout", {63'b0, cout2}, {63'b0, r[2]});
    chk("w2_eq", {63'b0, eq2}, {63'b0, av == bv});
  endtask

  task automatic op32(input logic m, input logic [31:0] av, input logic [31:0] bv, input logic ci);
    int lat = 0;
    logic [63:0] r = model(32, m, av, bv, ci);
    @(negedge clk);
    mode32 = m; a32 = av; b32 = bv; cin32 = ci; start32 = 1;
    @(posedge clk); #1;
    start32 = 0; b32 = ~bv;
    do begin @(posedge clk); #1; lat++; end while (!done32 && lat < 80);
    chk("w32_latency", 64'(lat), 64'd32);
    chk("w32_sum", {32'b0, sum32}, r & 64'hFFFF_FFFF);
    chk("w32_cout", {63'b0, cout32}, {63'b0, r[32]});
    chk("w32_eq", {63'b0, eq32}, {63'b0, av == bv});
  endtask

  initial begin
    int lat, n;
    logic bok, ov_en;
`ifdef SERIAL_ADDSUB_OVF_EN
    ov_en = 1;
`else
    ov_en = 0;
`endif
    v[0] = '{0, 8'h5A, 8'h3C, 0, 8'h96, 0, 0, 1};
    v[1] = '{0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0};
    v[2] = '{0, 8'h7F, 8'h00, 1, 8'h80, 0, 0, 1};
    v[3] = '{1, 8'h10, 8'h01, 0, 8'h0F, 1, 0, 0};
    v[4] = '{1, 8'h01, 8'h02, 0, 8'hFF, 0, 0, 0};
    v[5] = '{1, 8'hA5, 8'hA5, 0, 8'h00, 1, 1, 0};
    v[6] = '{0, 8'hA5, 8'hA5, 1, 8'h4B, 1, 1, 1};
    v[7] = '{1, 8'h80, 8'h01, 0, 8'h7F, 1, 0, 1};
    v[8] = '{1, 8'h05, 8'h03, 1, 8'h02, 1, 0, 0};

    #3;
    chk("rst_busy", {63'b0, busy}, 0);
    chk("rst_done", {63'b0, done}, 0);
    chk("rst_outs", {52'b0, sum, cout, eq, ovf}, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      op8(v[i].m, v[i].a, v[i].b, v[i].ci, lat, bok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
      chk($sformatf("v%0d_busy_run", i), {63'b0, bok}, 1);
      chk($sformatf("v%0d_busy_done", i), {63'b0, busy}, 0);
      chk($sformatf("v%0d_sum", i), {56'b0, sum}, {56'b0, v[i].s});
      chk($sformatf("v%0d_cout", i), {63'b0, cout}, {63'b0, v[i].co});
      chk($sformatf("v%0d_eq", i), {63'b0, eq}, {63'b0, v[i].e});
      chk($sformatf("v%0d_ovf", i), {63'b0, ovf}, {63'b0, v[i].o & ov_en});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {63'b0, done}, 0);
      chk($sformatf("v%0d_sum_hold", i), {56'b0, sum}, {56'b0, v[i].s});
    end

    // start during RUN is ignored and results do not move mid-run
    @(negedge clk); mode = 0; a = 8'h5A; b = 8'h3C; cin = 0; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1; mode = 1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1; start = 0;
    chk("hs_sum_midrun", {56'b0, sum}, 64'h02);
    chk("hs_busy_midrun", {63'b0, busy}, 1);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 40);
    chk("hs_ignored_latency", 64'(lat), 64'd5);
    chk("hs_sum", {56'b0, sum}, 64'h96);
    chk("hs_eq", {63'b0, eq}, 0);
    @(posedge clk); #1;
    chk("hs_no_requeue", {63'b0, busy | done}, 0);

    // back-to-back: start held high through DONE
    @(negedge clk); mode = 0; a = 8'h01; b = 8'h02; cin = 0; start = 1;
    @(posedge clk); #1; a = 8'h10; b = 8'h20; cin = 1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 40);
    chk("b2b_first_latency", 64'(lat), 64'd8);
    chk("b2b_first_sum", {56'b0, sum}, 64'h03);
    @(posedge clk); #1; start = 0;
    chk("b2b_no_idle", {63'b0, busy}, 1);
    n = 1;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    chk("b2b_done_spacing", 64'(n), 64'd9);
    chk("b2b_second_sum", {56'b0, sum}, 64'h31);

    // asynchronous reset mid-RUN
    @(negedge clk); mode = 0; a = 8'h5A; b = 8'h3C; cin = 0; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 0);
    chk("rst_mid_done", {63'b0, done}, 0);
    chk("rst_mid_outs", {52'b0, sum, cout, eq, ovf}, 0);
    @(negedge clk); rst_n = 1;
    n = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) n++; end
    chk("rst_no_done", 64'(n), 0);

    for (int i = 0; i < 10; i++) begin
      logic [1:0] x = 2'($urandom);
      op2(1'($urandom), x, (i % 4 == 0) ? x : 2'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] x = $urandom;
      op32(1'($urandom), x, (i % 4 == 0) ? x : $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor built around a 1-bit full-adder cell; next generation of the team's combinational gate/full-adder lab blocks.
- Accepts two WIDTH-bit operands, processes one bit per clock, LSB first.
- Reports sum/difference, carry-out and an equality flag, using a start/busy/done handshake.
- Sits as a small arithmetic datapath peripheral driven by a lab-level controller.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 2..32).
- CW, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when not busy.
- mode  in  1  0 = add (a+b+cin), 1 = subtract (a-b = a+~b+1, cin ignored).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, add mode only.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; results valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  final carry (subtract: 1 = no borrow).
- eq  out  1  1 when a == b (serial XNOR-AND chain).
- ovf  out  1  signed overflow (see Optional Feature).

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - state = IDLE; busy, done, sum, cout, eq, ovf = 0.
  - Internal shift registers and bit counter = 0.
- State machine IDLE / RUN / DONE.
- IDLE or DONE with start = 1:
  - Latch a, b (b inverted in subtract), mode.
  - Carry register = cin (add) or 1 (subtract); eq accumulator = 1; count = 0.
  - Go to RUN. Otherwise IDLE.
- RUN, one bit per cycle:
  - Full-adder cell computes bit `count` from the shifted operand LSBs and the carry register.
  - Sum bit shifts into the result MSB; carry register updates; eq accumulator ANDs in XNOR of the raw a/b bits.
  - count increments. After the cycle with count = WIDTH-1, go to DONE.
- DONE, exactly one cycle:
  - done = 1, busy = 0.
  - sum, cout, eq, ovf update to final values at the edge entering DONE.
  - Next state is IDLE, or RUN if start = 1 (back-to-back).
- busy = 1 exactly during the WIDTH RUN cycles.
- Latency:
  - start sampled at edge E0; busy high from E0 to E0+WIDTH.
  - done high for the cycle following E0+WIDTH.
- Output holding: outputs keep their last values in IDLE. They change only at the edge entering DONE, never mid-RUN (results are built in an internal shift register).
- start while busy: ignored; operands and mode are not re-latched.
- Operand inputs may change freely after acceptance.
- Arithmetic: modulo 2^WIDTH. Add cout = carry out of the MSB. Subtract cout = NOT borrow.
- Reset mid-RUN: immediate abort to the reset values; no done pulse.

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- When defined:
  - ovf = carry-in XOR carry-out of the MSB cell (two's-complement overflow).
  - Captured on entry to DONE; held like sum.
- When undefined: ovf is tied to 0 and the MSB carry-in tap register is omitted. The port list is unchanged.

Decomposition:
- Package serial_addsub_pkg:
  - state enum (IDLE, RUN, DONE).
  - mode constants MODE_ADD = 1'b0, MODE_SUB = 1'b1.
- One sub-module, full_adder_cell: combinational, inputs a, b, ci; outputs s = a^b^ci, co = ab | ci(a^b). Instantiated once.

Test Plan (all at WIDTH = 8):
- Add: a = 0x5A, b = 0x3C, cin = 0, start at E0 -> busy for 8 cycles, done at cycle E0+8; sum = 0x96, cout = 0, eq = 0, ovf = 1 (with macro).
- Wrap: add a = 0xFF, b = 0x01, cin = 0 -> sum = 0x00, cout = 1, ovf = 0. Then add a = 0x7F, b = 0x00, cin = 1 -> sum = 0x80, ovf = 1 (0 without macro).
- Subtract and equality:
  - a = 0x10, b = 0x01 -> sum = 0x0F, cout = 1.
  - a = 0x01, b = 0x02 -> sum = 0xFF, cout = 0.
  - a = b = 0xA5 -> sum = 0x00, eq = 1.
- Handshake: pulse start again at E0+3 with different operands -> ignored; first result unchanged. start held high through DONE -> second operation begins with no idle cycle, and done pulses again 9 cycles after the first.
- Reset mid-op: assert rst_n = 0 at E0+4 -> busy, done, sum, cout, eq drop to 0 asynchronously. After release, no done pulse until a new start.
- Sweep WIDTH = 2 and WIDTH = 32 with random operands vs a reference model -> sum, cout, eq match. done appears exactly WIDTH cycles after acceptance.
